// File: rtl/uart_sample_framer.sv
// Buffers {address, data} samples in a small FIFO and emits each one as a 5-byte
// checksummed packet, one byte per BYTE_PERIOD, over a held RQ/data interface.
module uart_sample_framer #(
  parameter int         FIFO_AW     = 3,
  parameter int         BYTE_PERIOD = 7000,
  parameter int         RQ_WIDTH    = 16,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] data,
  input  logic [4:0]  address,
  input  logic        valid,
  output logic        sendUART,
  output logic [7:0]  sendDATA,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  dropCount
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int PW    = FIFO_AW + 1;
  localparam int CW    = (BYTE_PERIOD > 2) ? $clog2(BYTE_PERIOD) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(BYTE_PERIOD - 2);
  localparam logic [CW-1:0] RQ_LAST  = CW'(RQ_WIDTH - 1);
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2,
    GAP  = 2'd3
  } state_t;

  // Packet byte idx of a stored {address, data} entry; byte 4 is the XOR of bytes 1..3.
  function automatic logic [7:0] pkt_byte(input logic [16:0] entry, input logic [2:0] idx);
    logic [7:0] b1;
    logic [7:0] b2;
    logic [7:0] b3;
    b1 = {3'b000, entry[16:12]};
    b2 = {4'h0, entry[11:8]};
    b3 = entry[7:0];
    case (idx)
      3'd0:    pkt_byte = SYNC_BYTE;
      3'd1:    pkt_byte = b1;
      3'd2:    pkt_byte = b2;
      3'd3:    pkt_byte = b3;
      default: pkt_byte = b1 ^ b2 ^ b3;
    endcase
  endfunction

  logic [16:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] level_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  state_t        state_r;
  state_t        state_n;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_n;
  logic [2:0]    idx_r;
  logic [2:0]    idx_n;
  logic [16:0]   entry_r;
  logic [16:0]   pkt_r;
  logic          rq_r;
  logic          rq_n;
  logic [7:0]    byte_r;
  logic [7:0]    byte_n;
  logic          busy_r;
  logic          overflow_r;
  logic [7:0]    drop_cnt_r;

  // A full FIFO still accepts a push when IDLE pops on the same edge.
  assign level_s = wr_ptr_r - rd_ptr_r;
  assign empty_s = (level_s == {PW{1'b0}});
  assign full_s  = (level_s == FULL_LVL);
  assign pop_s   = (state_r == IDLE) && !empty_s;
  assign push_s  = valid && (!full_s || pop_s);
  assign drop_s  = valid && !push_s;

  // Sample storage; validity is defined by the pointers, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r[FIFO_AW-1:0]] <= {address, data};
    end
  end

  // Next state plus next values of the registered RQ and byte outputs.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    rq_n    = 1'b0;
    byte_n  = byte_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          state_n = LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        idx_n   = 3'd0;
        state_n = SEND;
        rq_n    = 1'b1;
        byte_n  = SYNC_BYTE;
      end
      SEND: begin
        cnt_n   = {CW{1'b0}};
        state_n = GAP;
        rq_n    = (RQ_LAST != {CW{1'b0}});
      end
      GAP: begin
        if (cnt_r == LAST_CNT) begin
          cnt_n = {CW{1'b0}};
          if (idx_r < 3'd4) begin
            idx_n   = idx_r + 3'd1;
            state_n = SEND;
            rq_n    = 1'b1;
            byte_n  = pkt_byte(pkt_r, idx_r + 3'd1);
          end else begin
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt_r + CW'(1);
          rq_n  = (cnt_n < RQ_LAST);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM, FIFO pointers, packet register and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      idx_r      <= 3'd0;
      wr_ptr_r   <= {PW{1'b0}};
      rd_ptr_r   <= {PW{1'b0}};
      entry_r    <= 17'd0;
      pkt_r      <= 17'd0;
      rq_r       <= 1'b0;
      byte_r     <= 8'h00;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      idx_r      <= idx_n;
      rq_r       <= rq_n;
      byte_r     <= byte_n;
      busy_r     <= (state_n != IDLE);
      overflow_r <= drop_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        entry_r  <= mem_r[rd_ptr_r[FIFO_AW-1:0]];
      end
      if (state_r == LOAD) begin
        pkt_r <= entry_r;
      end
      if (drop_s && (drop_cnt_r != 8'hFF)) begin
        drop_cnt_r <= drop_cnt_r + 8'd1;
      end
    end
  end

  assign sendUART  = rq_r;
  assign sendDATA  = byte_r;
  assign busy      = busy_r;
  assign overflow  = overflow_r;
  assign dropCount = drop_cnt_r;

endmodule
